// File: rtl/if_id_hazard_ctrl_pkg.sv
// Shared definitions for the PC / IF/ID sequencer.
//   - ctrl_state_e : sequencer states (encoding is visible on the debug port)
//   - ctrl_out_t   : the four pipeline-control strobes, bundled
//   - NOP_INSTR    : word the IF/ID register loads when flushed (addi x0,x0,0)
//   - REG_AW_DEF   : default register-index width
package if_id_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LU_STALL   = 2'd1,
        ST_FETCH_WAIT = 2'd2
    } ctrl_state_e;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          REG_AW_DEF = 5;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
    } ctrl_out_t;

    // Strobe patterns used by the sequencer.
    localparam ctrl_out_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};
    localparam ctrl_out_t CTRL_SQUASH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};
    localparam ctrl_out_t CTRL_BUBBLE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};
    localparam ctrl_out_t CTRL_NOFET  = '{pc_write: 1'b0, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b0};
    localparam ctrl_out_t CTRL_RST    = '{pc_write: 1'b0, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};

endpackage

// File: rtl/if_id_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard compare.
// A hazard exists when the EX instruction is a load writing a non-zero
// register that the ID instruction actually reads.
//   i_id_rs1/i_id_rs2         : source registers of the ID instruction
//   i_id_use_rs1/i_id_use_rs2 : ID instruction really reads that source
//   i_ex_rd, i_ex_mem_read    : destination / load flag of the EX instruction
//   o_hazard                  : load-use hazard this cycle
module load_use_detect
    import if_id_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_mem_read,
    output logic              o_hazard
);

    logic w_rd_nz;
    logic w_hit1;
    logic w_hit2;

    // x0 never carries a dependency.
    assign w_rd_nz  = (i_ex_rd != '0);
    assign w_hit1   = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_hit2   = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    assign o_hazard = i_ex_mem_read && w_rd_nz && (w_hit1 || w_hit2);

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// Sequencer for the PC and the IF/ID pipeline register.
// Drives PC write-enable, IF/ID write/flush and the ID/EX bubble from the
// current state and the EX/ID/fetch inputs (same cycle), and keeps saturating
// stall/flush counters plus a sticky fetch-timeout flag.
//   i_clk, i_reset (async, active low)
//   i_imem_ready                    : instruction memory word valid this cycle
//   i_id_rs1/2, i_id_use_rs1/2      : ID instruction sources
//   i_ex_rd, i_ex_mem_read          : EX instruction destination / load flag
//   i_br_taken                      : taken branch resolved in EX
//   i_clr_cnt                       : sync clear of counters and timeout flag
//   o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble : pipeline strobes
//   o_ctrl_state                    : current state (debug)
//   o_stall_cnt, o_flush_cnt        : saturating perf counters
//   o_fetch_timeout                 : sticky, fetch wait exceeded WAIT_MAX
module if_id_hazard_ctrl
    import if_id_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int LOAD_LAT = 1,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_imem_ready,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_mem_read,
    input  logic              i_br_taken,
    input  logic              i_clr_cnt,
    output logic              o_pc_write,
    output logic              o_ifid_write,
    output logic              o_ifid_flush,
    output logic              o_idex_bubble,
    output logic [1:0]        o_ctrl_state,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt,
    output logic              o_fetch_timeout
);

    localparam int LU_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT + 1) : 1;
    localparam int WC_W = $clog2(WAIT_MAX + 1);
    localparam logic [LU_W-1:0]  LU_INIT = LU_W'(LOAD_LAT - 1);
    localparam logic [WC_W-1:0]  WC_MAX  = WC_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    ctrl_state_e      r_state;
    logic [LU_W-1:0]  r_lu_left;
    logic [WC_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             r_fetch_timeout;

    ctrl_state_e      w_state_nxt;
    logic [LU_W-1:0]  w_lu_nxt;
    logic [WC_W-1:0]  w_wait_nxt;
    logic             w_tmo_set;
    logic             w_hazard;
    ctrl_out_t        w_ctrl;

    load_use_detect #(.REG_AW(REG_AW)) u_lud (
        .i_id_rs1      (i_id_rs1),
        .i_id_rs2      (i_id_rs2),
        .i_id_use_rs1  (i_id_use_rs1),
        .i_id_use_rs2  (i_id_use_rs2),
        .i_ex_rd       (i_ex_rd),
        .i_ex_mem_read (i_ex_mem_read),
        .o_hazard      (w_hazard)
    );

    // Next state and strobes. Priority: branch > load-use (RUN only) > fetch.
    always_comb begin
        w_ctrl      = CTRL_RUN;
        w_state_nxt = r_state;
        w_lu_nxt    = r_lu_left;
        w_wait_nxt  = r_wait_cnt;
        w_tmo_set   = 1'b0;
        if (!i_reset) begin
            // Strobes follow reset asynchronously; registers are held by the ff.
            w_ctrl = CTRL_RST;
        end else if (i_br_taken) begin
            // Redirect: squash IF/ID and ID/EX, restart any pending fetch wait.
            w_ctrl      = CTRL_SQUASH;
            w_state_nxt = i_imem_ready ? ST_RUN : ST_FETCH_WAIT;
            w_lu_nxt    = '0;
            w_wait_nxt  = '0;
        end else if (r_state == ST_LU_STALL) begin
            // First bubble was issued from RUN; lu_left counts the remainder.
            w_ctrl   = CTRL_BUBBLE;
            w_lu_nxt = r_lu_left - LU_W'(1);
            if (r_lu_left == LU_W'(1)) begin
                w_state_nxt = ST_RUN;
            end
        end else if (r_state == ST_RUN && w_hazard) begin
            w_ctrl = CTRL_BUBBLE;
            if (LOAD_LAT > 1) begin
                w_state_nxt = ST_LU_STALL;
                w_lu_nxt    = LU_INIT;
            end
        end else if (i_imem_ready) begin
            w_ctrl      = CTRL_RUN;
            w_state_nxt = ST_RUN;
            w_wait_nxt  = '0;
        end else begin
            // No fetch word: let ID advance but feed a NOP into IF/ID.
            w_ctrl      = CTRL_NOFET;
            w_state_nxt = ST_FETCH_WAIT;
            if (r_state == ST_FETCH_WAIT) begin
                // Count saturates at WAIT_MAX; the flag carries the rest.
                if (r_wait_cnt == WC_MAX) begin
                    w_tmo_set = 1'b1;
                end else begin
                    w_wait_nxt = r_wait_cnt + WC_W'(1);
                end
            end else begin
                w_wait_nxt = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state         <= ST_FETCH_WAIT;
            r_lu_left       <= '0;
            r_wait_cnt      <= '0;
            r_stall_cnt     <= '0;
            r_flush_cnt     <= '0;
            r_fetch_timeout <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lu_left  <= w_lu_nxt;
            r_wait_cnt <= w_wait_nxt;
            // Clear beats a same-cycle increment or timeout set.
            if (i_clr_cnt) begin
                r_stall_cnt     <= '0;
                r_flush_cnt     <= '0;
                r_fetch_timeout <= 1'b0;
            end else begin
                if (!w_ctrl.pc_write && r_stall_cnt != CNT_SAT) begin
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                end
                if (i_br_taken && r_flush_cnt != CNT_SAT) begin
                    r_flush_cnt <= r_flush_cnt + CNT_W'(1);
                end
                if (w_tmo_set) begin
                    r_fetch_timeout <= 1'b1;
                end
            end
        end
    end

    assign o_pc_write      = w_ctrl.pc_write;
    assign o_ifid_write    = w_ctrl.ifid_write;
    assign o_ifid_flush    = w_ctrl.ifid_flush;
    assign o_idex_bubble   = w_ctrl.idex_bubble;
    assign o_ctrl_state    = r_state;
    assign o_stall_cnt     = r_stall_cnt;
    assign o_flush_cnt     = r_flush_cnt;
    assign o_fetch_timeout = r_fetch_timeout;

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Bench for if_id_hazard_ctrl: two instances (LOAD_LAT=1/CNT_W=16 and
// LOAD_LAT=3/CNT_W=4) share stimulus; a cycle model pushes expected strobes,
// state and counters to a queue per instance, popped and compared each cycle.
module tb_if_id_hazard_ctrl;

  logic       gclk = 1'b0;
  logic       rst_n, imem_ready, use1, use2, ex_mem_read, br_taken, clr_cnt;
  logic [4:0] id_rs1, id_rs2, ex_rd;

  logic       a_pc, a_ifw, a_fl, a_bub, a_tmo;
  logic [1:0] a_st;
  logic [15:0] a_sc, a_fc;
  logic       b_pc, b_ifw, b_fl, b_bub, b_tmo;
  logic [1:0] b_st;
  logic [3:0] b_sc, b_fc;

  always #5 gclk = ~gclk;

  if_id_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .WAIT_MAX(15), .CNT_W(16)) u_dut_a (
    .i_clk(gclk), .i_reset(rst_n), .i_imem_ready(imem_ready),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
    .i_ex_rd(ex_rd), .i_ex_mem_read(ex_mem_read), .i_br_taken(br_taken), .i_clr_cnt(clr_cnt),
    .o_pc_write(a_pc), .o_ifid_write(a_ifw), .o_ifid_flush(a_fl), .o_idex_bubble(a_bub),
    .o_ctrl_state(a_st), .o_stall_cnt(a_sc), .o_flush_cnt(a_fc), .o_fetch_timeout(a_tmo));

  if_id_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .WAIT_MAX(15), .CNT_W(4)) u_dut_b (
    .i_clk(gclk), .i_reset(rst_n), .i_imem_ready(imem_ready),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
    .i_ex_rd(ex_rd), .i_ex_mem_read(ex_mem_read), .i_br_taken(br_taken), .i_clr_cnt(clr_cnt),
    .o_pc_write(b_pc), .o_ifid_write(b_ifw), .o_ifid_flush(b_fl), .o_idex_bubble(b_bub),
    .o_ctrl_state(b_st), .o_stall_cnt(b_sc), .o_flush_cnt(b_fc), .o_fetch_timeout(b_tmo));

  typedef struct packed {
    logic [1:0] st; logic [7:0] lu; logic [7:0] wc;
    logic [15:0] sc; logic [15:0] fc; logic tmo;
  } mdl_t;
  typedef struct packed {
    logic [3:0] ctl; logic [1:0] st; logic [15:0] sc; logic [15:0] fc; logic tmo;
  } exp_t;

  localparam mdl_t MDL_RST = '{st: 2'd2, lu: 8'd0, wc: 8'd0, sc: 16'd0, fc: 16'd0, tmo: 1'b0};

  exp_t sbq_a[$];
  exp_t sbq_b[$];
  mdl_t ma, mb, na, nb;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: ctl = {pc_write, ifid_write, ifid_flush, idex_bubble}.
  task automatic ref_eval(input mdl_t m, input int lat, input int wmax, input int cw,
                          output logic [3:0] o, output mdl_t n);
    logic        hz;
    logic [15:0] cmax;
    cmax = 16'((32'd1 << cw) - 1);
    hz = ex_mem_read && (ex_rd != 5'd0) &&
         ((use1 && id_rs1 == ex_rd) || (use2 && id_rs2 == ex_rd));
    n = m;
    o = 4'b1100;
    if (!rst_n) begin
      o = 4'b0111;
      n = MDL_RST;
    end else begin
      if (br_taken) begin
        o = 4'b1111; n.st = imem_ready ? 2'd0 : 2'd2; n.lu = 8'd0; n.wc = 8'd0;
      end else if (m.st == 2'd1) begin
        o = 4'b0001; n.lu = m.lu - 8'd1;
        if (m.lu == 8'd1) n.st = 2'd0;
      end else if (m.st == 2'd0 && hz) begin
        o = 4'b0001;
        if (lat > 1) begin n.st = 2'd1; n.lu = 8'(lat - 1); end
      end else if (imem_ready) begin
        o = 4'b1100; n.st = 2'd0; n.wc = 8'd0;
      end else begin
        o = 4'b0110; n.st = 2'd2;
        if (m.st == 2'd2) begin
          if (int'(m.wc) == wmax) n.tmo = 1'b1;
          else n.wc = m.wc + 8'd1;
        end else begin
          n.wc = 8'd0;
        end
      end
      if (!o[3] && m.sc < cmax) n.sc = m.sc + 16'd1;
      if (br_taken && m.fc < cmax) n.fc = m.fc + 16'd1;
      if (clr_cnt) begin n.sc = 16'd0; n.fc = 16'd0; n.tmo = 1'b0; end
    end
  endtask

  task automatic cmp_all(input string tag, input exp_t g, input exp_t e);
    chk({tag, ".ctl"}, 32'(g.ctl), 32'(e.ctl));
    chk({tag, ".st"},  32'(g.st),  32'(e.st));
    chk({tag, ".sc"},  32'(g.sc),  32'(e.sc));
    chk({tag, ".fc"},  32'(g.fc),  32'(e.fc));
    chk({tag, ".tmo"}, 32'(g.tmo), 32'(e.tmo));
  endtask

  // Called right after inputs are driven on a negedge; returns on the next negedge.
  task automatic cycle(input string tag);
    logic [3:0] oa, ob;
    exp_t ea, eb, ga, gb;
    #1;
    if (!rst_n) begin ma = MDL_RST; mb = MDL_RST; end
    ref_eval(ma, 1, 15, 16, oa, na);
    ref_eval(mb, 3, 15, 4, ob, nb);
    sbq_a.push_back('{ctl: oa, st: ma.st, sc: ma.sc, fc: ma.fc, tmo: ma.tmo});
    sbq_b.push_back('{ctl: ob, st: mb.st, sc: mb.sc, fc: mb.fc, tmo: mb.tmo});
    ga = '{ctl: {a_pc, a_ifw, a_fl, a_bub}, st: a_st, sc: a_sc, fc: a_fc, tmo: a_tmo};
    gb = '{ctl: {b_pc, b_ifw, b_fl, b_bub}, st: b_st, sc: 16'(b_sc), fc: 16'(b_fc), tmo: b_tmo};
    ea = sbq_a.pop_front();
    eb = sbq_b.pop_front();
    cmp_all({tag, "/a"}, ga, ea);
    cmp_all({tag, "/b"}, gb, eb);
    @(posedge gclk);
    ma = na;
    mb = nb;
    @(negedge gclk);
  endtask

  task automatic set_hz(input logic [4:0] rd);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = rd; use1 = 1'b1; use2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_seen;
    rst_n = 1'b0; imem_ready = 1'b0; use1 = 1'b0; use2 = 1'b0; ex_mem_read = 1'b0;
    br_taken = 1'b0; clr_cnt = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    ma = MDL_RST; mb = MDL_RST;
    @(negedge gclk);
    cycle("rst"); cycle("rst2");
    rst_n = 1'b1; cycle("fw0");
    imem_ready = 1'b1; cycle("fw_exit");
    repeat (3) cycle("run");

    // Load-use on rs1: one bubble (a) vs three bubbles (b).
    set_hz(5'd5); cycle("lu_rs1");
    ex_mem_read = 1'b0; repeat (4) cycle("lu_rs1_after");
    chk("a_stall1", 32'(a_sc), 32'd2);
    // Load-use on rs2.
    id_rs1 = 5'd1; id_rs2 = 5'd7; use1 = 1'b1; use2 = 1'b1; ex_rd = 5'd7; ex_mem_read = 1'b1;
    cycle("lu_rs2");
    ex_mem_read = 1'b0; repeat (3) cycle("lu_rs2_after");
    // No hazard: x0 destination, unused source, non-load.
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; cycle("rd0");
    ex_rd = 5'd3; id_rs1 = 5'd3; use1 = 1'b0; id_rs2 = 5'd4; cycle("nouse");
    ex_mem_read = 1'b0; use1 = 1'b1; cycle("noload");

    // Branch beats hazard and missing fetch.
    set_hz(5'd5); imem_ready = 1'b0; br_taken = 1'b1; cycle("br_hz");
    br_taken = 1'b0; ex_mem_read = 1'b0; cycle("br_fw");
    chk("a_fc_br", 32'(a_fc), 32'd1);
    imem_ready = 1'b1; repeat (2) cycle("br_run");
    // Branch during LU_STALL of b.
    set_hz(5'd6); cycle("lu_pre_br");
    ex_mem_read = 1'b0; br_taken = 1'b1; cycle("br_lu");
    br_taken = 1'b0; repeat (2) cycle("br_lu_after");

    // Fetch timeout: 20 cycles without a fetch word starting from RUN.
    imem_ready = 1'b0; first_seen = -1;
    for (int i = 0; i < 20; i++) begin
      cycle("to");
      if (a_tmo === 1'b1 && first_seen < 0) first_seen = i;
    end
    chk("to_at", 32'(first_seen), 32'd16);
    imem_ready = 1'b1; repeat (3) cycle("to_hold");
    chk("to_sticky", 32'(a_tmo), 32'd1);
    clr_cnt = 1'b1; cycle("to_clr");
    clr_cnt = 1'b0; cycle("to_post");
    chk("to_cleared", 32'(a_tmo), 32'd0);

    // Reset while b sits in LU_STALL.
    set_hz(5'd9); cycle("lu_pre_rst");
    ex_mem_read = 1'b0;
    chk("b_in_lu", 32'(b_st), 32'd1);
    rst_n = 1'b0; cycle("rst_mid");
    rst_n = 1'b1; imem_ready = 1'b0; cycle("post_rst");
    imem_ready = 1'b1; cycle("post_rst_run");

    // Counter saturation on the 4-bit instance, then clear against a stall.
    imem_ready = 1'b0; clr_cnt = 1'b1; cycle("sat_clr0");
    clr_cnt = 1'b0; repeat (20) cycle("sat");
    chk("b_sat", 32'(b_sc), 32'd15);
    clr_cnt = 1'b1; cycle("sat_clr");
    clr_cnt = 1'b0;
    chk("b_clr_wins", 32'(b_sc), 32'd0);
    imem_ready = 1'b1; cycle("sat_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
